// File: rtl/aclk_time_counter_p_if.sv
// Bundles the control, load and display signals of the alarm-clock time counter.
// The counter is the slave; the timebase/control side that drives it is the master.
interface aclk_time_counter_p_if;
  logic       tick;
  logic       hold;
  logic       mode_12h;
  logic       load_new_c;
  logic [3:0] new_hr_ms;
  logic [3:0] new_hr_ls;
  logic [3:0] new_min_ms;
  logic [3:0] new_min_ls;
  logic [3:0] new_sec_ms;
  logic [3:0] new_sec_ls;
  logic [3:0] cur_hr_ms;
  logic [3:0] cur_hr_ls;
  logic [3:0] cur_min_ms;
  logic [3:0] cur_min_ls;
  logic [3:0] cur_sec_ms;
  logic [3:0] cur_sec_ls;
  logic       pm;
  logic       day_wrap;
  logic       load_err;

  // Strobes (tick, load_new_c) are single-cycle pulses sampled on the rising
  // clock edge; there is no back-pressure, every sampled strobe is consumed.
  modport master (
    output tick, hold, mode_12h, load_new_c,
    output new_hr_ms, new_hr_ls, new_min_ms, new_min_ls, new_sec_ms, new_sec_ls,
    input  cur_hr_ms, cur_hr_ls, cur_min_ms, cur_min_ls, cur_sec_ms, cur_sec_ls,
    input  pm, day_wrap, load_err
  );

  modport slave (
    input  tick, hold, mode_12h, load_new_c,
    input  new_hr_ms, new_hr_ls, new_min_ms, new_min_ls, new_sec_ms, new_sec_ls,
    output cur_hr_ms, cur_hr_ls, cur_min_ms, cur_min_ls, cur_sec_ms, cur_sec_ls,
    output pm, day_wrap, load_err
  );
endinterface

// File: rtl/aclk_time_counter_p.sv
// 24-hour BCD time-of-day counter with prescaled tick, validated load, hold,
// combinational 12-hour view and a one-cycle midnight wrap pulse.
module aclk_time_counter_p #(
  parameter int HAS_SECONDS = 1,
  parameter int PRESCALE    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  aclk_time_counter_p_if.slave bus
);

  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  logic [3:0]  hr_ms, hr_ls, min_ms, min_ls, sec_ms, sec_ls;
  logic [3:0]  hr_ms_n, hr_ls_n, min_ms_n, min_ls_n, sec_ms_n, sec_ls_n;
  logic [15:0] pcnt, pcnt_n;
  logic        day_wrap_q, load_err_q;

  logic load_ok, sec_ok, load_take, accept_tick, advance;
  logic c_sl, c_sm, min_in, c_ml, hour_in, at_23, wrap;

  assign sec_ok  = (HAS_SECONDS == 0) ||
                   ((bus.new_sec_ms <= 4'd5) && (bus.new_sec_ls <= 4'd9));
  assign load_ok = (bus.new_hr_ms <= 4'd2) && (bus.new_hr_ls <= 4'd9) &&
                   !((bus.new_hr_ms == 4'd2) && (bus.new_hr_ls > 4'd3)) &&
                   (bus.new_min_ms <= 4'd5) && (bus.new_min_ls <= 4'd9) && sec_ok;

  assign load_take = bus.load_new_c && load_ok;
  // A rejected load does not swallow the tick; an accepted one does.
  assign accept_tick = bus.tick && !bus.hold && !load_take;
  assign advance     = accept_tick && (pcnt == PS_LAST);

  // Carry chain: each term is true only when every lower digit rolls over.
  assign c_sl    = advance && (sec_ls == 4'd9);
  assign c_sm    = c_sl && (sec_ms == 4'd5);
  assign min_in  = (HAS_SECONDS != 0) ? c_sm : advance;
  assign c_ml    = min_in && (min_ls == 4'd9);
  assign hour_in = c_ml && (min_ms == 4'd5);
  assign at_23   = (hr_ms == 4'd2) && (hr_ls == 4'd3);
  assign wrap    = hour_in && at_23;

  always_comb begin
    hr_ms_n  = hr_ms;
    hr_ls_n  = hr_ls;
    min_ms_n = min_ms;
    min_ls_n = min_ls;
    sec_ms_n = sec_ms;
    sec_ls_n = sec_ls;
    pcnt_n   = pcnt;
    if (load_take) begin
      hr_ms_n  = bus.new_hr_ms;
      hr_ls_n  = bus.new_hr_ls;
      min_ms_n = bus.new_min_ms;
      min_ls_n = bus.new_min_ls;
      sec_ms_n = (HAS_SECONDS != 0) ? bus.new_sec_ms : 4'd0;
      sec_ls_n = (HAS_SECONDS != 0) ? bus.new_sec_ls : 4'd0;
      pcnt_n   = 16'd0;
    end else if (accept_tick) begin
      pcnt_n = advance ? 16'd0 : pcnt + 16'd1;
      if (advance && (HAS_SECONDS != 0)) begin
        sec_ls_n = (sec_ls == 4'd9) ? 4'd0 : sec_ls + 4'd1;
      end
      if (c_sl && (HAS_SECONDS != 0)) begin
        sec_ms_n = (sec_ms == 4'd5) ? 4'd0 : sec_ms + 4'd1;
      end
      if (min_in) begin
        min_ls_n = (min_ls == 4'd9) ? 4'd0 : min_ls + 4'd1;
      end
      if (c_ml) begin
        min_ms_n = (min_ms == 4'd5) ? 4'd0 : min_ms + 4'd1;
      end
      if (hour_in) begin
        if (at_23) begin
          hr_ms_n = 4'd0;
          hr_ls_n = 4'd0;
        end else if (hr_ls == 4'd9) begin
          hr_ms_n = hr_ms + 4'd1;
          hr_ls_n = 4'd0;
        end else begin
          hr_ls_n = hr_ls + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hr_ms      <= 4'd0;
      hr_ls      <= 4'd0;
      min_ms     <= 4'd0;
      min_ls     <= 4'd0;
      sec_ms     <= 4'd0;
      sec_ls     <= 4'd0;
      pcnt       <= 16'd0;
      day_wrap_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      hr_ms      <= hr_ms_n;
      hr_ls      <= hr_ls_n;
      min_ms     <= min_ms_n;
      min_ls     <= min_ls_n;
      sec_ms     <= sec_ms_n;
      sec_ls     <= sec_ls_n;
      pcnt       <= pcnt_n;
      day_wrap_q <= wrap;
      load_err_q <= bus.load_new_c && !load_ok;
    end
  end

  // 12-hour view: 00 -> 12, 13..19 -> 01..07, 20/21 -> 08/09, 22/23 -> 10/11.
  logic [3:0] disp_hr_ms, disp_hr_ls;
  always_comb begin
    disp_hr_ms = hr_ms;
    disp_hr_ls = hr_ls;
    if (bus.mode_12h) begin
      if ((hr_ms == 4'd0) && (hr_ls == 4'd0)) begin
        disp_hr_ms = 4'd1;
        disp_hr_ls = 4'd2;
      end else if ((hr_ms == 4'd1) && (hr_ls >= 4'd3)) begin
        disp_hr_ms = 4'd0;
        disp_hr_ls = hr_ls - 4'd2;
      end else if (hr_ms == 4'd2) begin
        if (hr_ls <= 4'd1) begin
          disp_hr_ms = 4'd0;
          disp_hr_ls = hr_ls + 4'd8;
        end else begin
          disp_hr_ms = 4'd1;
          disp_hr_ls = hr_ls - 4'd2;
        end
      end
    end
  end

  assign bus.cur_hr_ms  = disp_hr_ms;
  assign bus.cur_hr_ls  = disp_hr_ls;
  assign bus.cur_min_ms = min_ms;
  assign bus.cur_min_ls = min_ls;
  assign bus.cur_sec_ms = (HAS_SECONDS != 0) ? sec_ms : 4'd0;
  assign bus.cur_sec_ls = (HAS_SECONDS != 0) ? sec_ls : 4'd0;
  assign bus.pm         = (hr_ms == 4'd2) || ((hr_ms == 4'd1) && (hr_ls >= 4'd2));
  assign bus.day_wrap   = day_wrap_q;
  assign bus.load_err   = load_err_q;

endmodule

// File: tb/tb_aclk_time_counter_p.sv
// Bench for aclk_time_counter_p: three configurations driven in lockstep and
// compared against a seconds-of-day reference model.
module tb_aclk_time_counter_p;

  localparam int ND = 3;
  localparam int EW = 19;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic tick = 1'b0, hold = 1'b0, mode_12h = 1'b0, load_new_c = 1'b0;
  logic [3:0] d_hm = '0, d_hl = '0, d_mm = '0, d_ml = '0, d_sm = '0, d_sl = '0;
  logic [26:0] obs [ND];

  always #5 clk = ~clk;

  // Instance 0: seconds, PRESCALE 1. Instance 1: seconds, PRESCALE 4.
  // Instance 2: minutes only, PRESCALE 3.
  for (genvar g = 0; g < ND; g++) begin : g_dut
    aclk_time_counter_p_if bus_if ();
    aclk_time_counter_p #(
      .HAS_SECONDS((g == 2) ? 0 : 1),
      .PRESCALE   ((g == 0) ? 1 : (g == 1) ? 4 : 3)
    ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus_if)
    );
    assign bus_if.tick       = tick;
    assign bus_if.hold       = hold;
    assign bus_if.mode_12h   = mode_12h;
    assign bus_if.load_new_c = load_new_c;
    assign bus_if.new_hr_ms  = d_hm;
    assign bus_if.new_hr_ls  = d_hl;
    assign bus_if.new_min_ms = d_mm;
    assign bus_if.new_min_ls = d_ml;
    assign bus_if.new_sec_ms = d_sm;
    assign bus_if.new_sec_ls = d_sl;
    assign obs[g] = {bus_if.cur_hr_ms, bus_if.cur_hr_ls, bus_if.cur_min_ms,
                     bus_if.cur_min_ls, bus_if.cur_sec_ms, bus_if.cur_sec_ls,
                     bus_if.pm, bus_if.day_wrap, bus_if.load_err};
  end

  int n_checks = 0;
  int n_pass = 0;
  string phase = "init";
  logic [ND*EW-1:0] exp_q[$];

  int m_t [ND];
  int m_pc [ND];
  bit m_dw [ND];
  bit m_le [ND];

  function automatic int has_sec(int k);
    return (k == 2) ? 0 : 1;
  endfunction

  function automatic int prescale(int k);
    return (k == 0) ? 1 : (k == 1) ? 4 : 3;
  endfunction

  task automatic check_eq(string tag, logic [26:0] got, logic [26:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h (hh mm ss pm wrap err)", tag, got, exp);
  endtask

  function automatic void model_reset();
    for (int k = 0; k < ND; k++) begin
      m_t[k] = 0; m_pc[k] = 0; m_dw[k] = 1'b0; m_le[k] = 1'b0;
    end
  endfunction

  // Reference: time kept as seconds since midnight, loads checked numerically.
  function automatic void model_step();
    int hr, mn, sc;
    bit ok;
    hr = int'(d_hm) * 10 + int'(d_hl);
    mn = int'(d_mm) * 10 + int'(d_ml);
    sc = int'(d_sm) * 10 + int'(d_sl);
    for (int k = 0; k < ND; k++) begin
      ok = (d_hl <= 9) && (d_ml <= 9) && (hr < 24) && (mn < 60) &&
           ((has_sec(k) == 0) || ((d_sl <= 9) && (sc < 60)));
      m_dw[k] = 1'b0;
      m_le[k] = 1'b0;
      if (load_new_c && ok) begin
        m_t[k] = hr * 3600 + mn * 60 + ((has_sec(k) != 0) ? sc : 0);
        m_pc[k] = 0;
      end else begin
        if (load_new_c) m_le[k] = 1'b1;
        if (tick && !hold) begin
          if (m_pc[k] == prescale(k) - 1) begin
            m_pc[k] = 0;
            m_t[k] = m_t[k] + ((has_sec(k) != 0) ? 1 : 60);
            if (m_t[k] >= 86400) begin
              m_t[k] = 0;
              m_dw[k] = 1'b1;
            end
          end else begin
            m_pc[k] = m_pc[k] + 1;
          end
        end
      end
    end
  endfunction

  function automatic logic [26:0] exp_word(int k, int t, bit dw, bit le, bit md);
    int hr, mn, sc, dh;
    bit is_pm;
    hr = t / 3600;
    mn = (t / 60) % 60;
    sc = (has_sec(k) != 0) ? t % 60 : 0;
    is_pm = (hr >= 12);
    dh = hr;
    if (md) begin
      if (hr == 0) dh = 12;
      else if (hr > 12) dh = hr - 12;
    end
    return {4'(dh / 10), 4'(dh % 10), 4'(mn / 10), 4'(mn % 10),
            4'(sc / 10), 4'(sc % 10), is_pm, dw, le};
  endfunction

  // One clock: model the inputs driven now, push, then compare after the edge.
  task automatic step();
    logic [ND*EW-1:0] e;
    logic [EW-1:0] s;
    model_step();
    for (int k = 0; k < ND; k++) e[k*EW +: EW] = {17'(m_t[k]), m_dw[k], m_le[k]};
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    for (int k = 0; k < ND; k++) begin
      s = e[k*EW +: EW];
      check_eq($sformatf("%s_dut%0d", phase, k), obs[k],
               exp_word(k, int'(s[18:2]), s[1], s[0], mode_12h));
    end
    tick = 1'b0;
    load_new_c = 1'b0;
  endtask

  task automatic do_load_raw(logic [3:0] hm, hl, mm, ml, sm, sl, bit with_tick);
    d_hm = hm; d_hl = hl; d_mm = mm; d_ml = ml; d_sm = sm; d_sl = sl;
    load_new_c = 1'b1;
    tick = with_tick;
    step();
  endtask

  task automatic do_load(int hr, int mn, int sc, bit with_tick);
    do_load_raw(4'(hr / 10), 4'(hr % 10), 4'(mn / 10), 4'(mn % 10),
                4'(sc / 10), 4'(sc % 10), with_tick);
  endtask

  task automatic do_ticks(int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    phase = "reset24";  step();
    phase = "reset12";  mode_12h = 1'b1; step();
    mode_12h = 1'b0;

    phase = "ripple";   do_load(9, 59, 59, 1'b0); do_ticks(5);
    phase = "wrap";     do_load(23, 59, 59, 1'b0); do_ticks(12); step();

    phase = "view12";   mode_12h = 1'b1; do_load(13, 5, 0, 1'b0); step();
    phase = "view24";   mode_12h = 1'b0; step();
    phase = "view_noon"; mode_12h = 1'b1; do_load(12, 0, 0, 1'b0); do_load(0, 59, 0, 1'b0);
    do_load(23, 30, 0, 1'b0); do_load(20, 1, 0, 1'b0);
    mode_12h = 1'b0;

    phase = "bad_hr24"; do_load(24, 0, 0, 1'b0); step();
    phase = "bad_min60"; do_load(19, 60, 0, 1'b0);
    phase = "bad_hl";   do_load_raw(4'd1, 4'd10, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    phase = "bad_sec60"; do_load(23, 59, 60, 1'b0);
    phase = "good_load"; do_load(23, 59, 59, 1'b0);
    phase = "bad_tick"; do_load(25, 0, 0, 1'b1); do_ticks(3);

    phase = "hold";     do_load(0, 0, 0, 1'b0); do_ticks(3);
    hold = 1'b1;        do_ticks(5);
    hold = 1'b0;        do_ticks(1);
    phase = "hold_load"; hold = 1'b1; do_load(5, 6, 7, 1'b1); hold = 1'b0;

    phase = "load_tick"; do_ticks(2); do_load(11, 59, 58, 1'b1); do_ticks(4);

    phase = "random";
    for (int i = 0; i < 200; i++) begin
      tick = 1'($urandom_range(0, 1));
      hold = ($urandom_range(0, 3) == 0);
      mode_12h = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 11) == 0) begin
        d_hm = 4'($urandom_range(0, 3)); d_hl = 4'($urandom_range(0, 10));
        d_mm = 4'($urandom_range(0, 6)); d_ml = 4'($urandom_range(0, 9));
        d_sm = 4'($urandom_range(0, 6)); d_sl = 4'($urandom_range(0, 9));
        load_new_c = 1'b1;
      end
      step();
    end
    hold = 1'b0;
    mode_12h = 1'b0;

    phase = "midreset"; do_load(14, 22, 33, 1'b0); do_ticks(6);
    tick = 1'b1;
    reset_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < ND; k++) check_eq($sformatf("midreset_now_dut%0d", k), obs[k], exp_word(k, 0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    @(negedge clk);
    tick = 1'b0;
    reset_n = 1'b1;
    phase = "after_reset"; do_ticks(5);
    phase = "min_wrap"; do_load(23, 59, 0, 1'b0); do_ticks(61); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
